// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input-conditioning stage.
package gpio_pkg;

  localparam int   GPIO_W        = 16;
  localparam logic EDGE_RISE     = 1'b0;
  localparam logic EDGE_FALL     = 1'b1;
  localparam int   DB_CNT_W      = 8;
  localparam int   DB_CYCLES_DEF = 4;

  // Pick the edge pulse that the pin's edge selector asks for.
  function automatic logic edge_hit(input logic sel, input logic rise, input logic fall);
    logic hit;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One pin: 2-flop synchronizer, counter debounce, and rise/fall pulse generation.
// The debounced level only changes after DB_CYCLES consecutive synchronized
// samples disagree with it; any agreeing sample restarts the count.
module gpio_db_bit
  import gpio_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_raw,
  output logic pin_db,
  output logic pin_rise,
  output logic pin_fall
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                db_q, db_d;
  logic                db_prev_q, db_prev_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: synchronizer shift, debounce count/commit, previous-level capture.
  always_comb begin
    sync1_d   = pin_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = {DB_CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = {DB_CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + DB_CNT_W'(1);
    end
  end

  // State registers; asynchronous reset discards any count in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= {DB_CNT_W{1'b0}};
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pin_db   = db_q;
  assign pin_rise = db_q & ~db_prev_q;
  assign pin_fall = ~db_q & db_prev_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin synchronize/debounce/edge detect, plus an
// optional sticky edge-interrupt pending register.
// Build option: GPIO_IRQ_EN enables irq_pend/irq; without it both read 0 and
// edge_sel, irq_en and irq_clr are ignored.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH     = GPIO_W,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_raw,
  input  logic [WIDTH-1:0] edge_sel,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] pin_db,
  output logic [WIDTH-1:0] pin_rise,
  output logic [WIDTH-1:0] pin_fall,
  output logic [WIDTH-1:0] irq_pend,
  output logic             irq
);

  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_db_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .pin_raw (pin_raw[i]),
      .pin_db  (pin_db[i]),
      .pin_rise(rise_s[i]),
      .pin_fall(fall_s[i])
    );
  end

  assign pin_rise = rise_s;
  assign pin_fall = fall_s;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] set_s;

  // Pending next-state: a selected, enabled edge sets; a clear pulse clears; set wins.
  always_comb begin
    set_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      set_s[i] = irq_en[i] & edge_hit(edge_sel[i], rise_s[i], fall_s[i]);
    end
    pend_d = set_s | (pend_q & ~irq_clr);
  end

  // Sticky pending flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= {WIDTH{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_pend = pend_q;
  assign irq      = |(pend_q & irq_en);
`else
  logic unused_irq_s;
  assign unused_irq_s = ^{edge_sel, irq_en, irq_clr};
  assign irq_pend     = {WIDTH{1'b0}};
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// Randomized scoreboard bench for gpio_in_cond. A reference model built from
// the pin history decides every cycle's expected outputs; a monitor compares.
module tb_gpio_in_cond;

  localparam int W      = 16;
  localparam int DB     = 4;
  localparam int NCYC   = 3000;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pin_raw, edge_sel, irq_en, irq_clr;
  logic [W-1:0] pin_db, pin_rise, pin_fall, irq_pend;
  logic         irq;

  gpio_in_cond #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .pin_raw (pin_raw),
    .edge_sel(edge_sel),
    .irq_en  (irq_en),
    .irq_clr (irq_clr),
    .pin_db  (pin_db),
    .pin_rise(pin_rise),
    .pin_fall(pin_fall),
    .irq_pend(irq_pend),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pend;
    logic         irq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: raw samples since reset release, indexed by edge number.
  logic [W-1:0] smp[$];
  logic [W-1:0] m_db, m_db_prev, m_pend;
  int           last_flip[W];
  int           t;

  function automatic logic sync_val(int j, int i);
    logic [W-1:0] v;
    if (j < 2) return 1'b0;
    v = smp[j-2];
    return v[i];
  endfunction

  task automatic model_clear();
    smp.delete();
    m_db = '0; m_db_prev = '0; m_pend = '0; t = 0;
    for (int i = 0; i < W; i++) last_flip[i] = -1;
  endtask

  // Applies one clock edge to the model using the inputs present before it.
  task automatic model_edge();
    logic [W-1:0] new_db, rise_old, fall_old;
    bit ok;
    if (!reset) begin
      model_clear();
    end else begin
      smp.push_back(pin_raw);
      rise_old = m_db & ~m_db_prev;
      fall_old = ~m_db & m_db_prev;
      new_db   = m_db;
      for (int i = 0; i < W; i++) begin
        if (t - last_flip[i] >= DB) begin
          ok = 1'b1;
          for (int j = t - DB + 1; j <= t; j++)
            if (sync_val(j, i) == m_db[i]) ok = 1'b0;
          if (ok) begin
            new_db[i]    = ~m_db[i];
            last_flip[i] = t;
          end
        end
      end
`ifdef GPIO_IRQ_EN
      m_pend = (irq_en & ((edge_sel & fall_old) | (~edge_sel & rise_old))) | (m_pend & ~irq_clr);
`endif
      m_db_prev = m_db;
      m_db      = new_db;
      t++;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.db   = m_db;
    e.rise = m_db & ~m_db_prev;
    e.fall = ~m_db & m_db_prev;
    e.pend = m_pend;
    e.irq  = |(m_pend & irq_en);
    exp_q.push_back(e);
  endtask

  // Stimulus: reset with pins high, then slow/glitchy random segments and occasional resets.
  initial begin
    logic [W-1:0] tog;
    int           prob;
    model_clear();
    reset = 1'b0; pin_raw = 16'hFFFF; edge_sel = 16'h0000; irq_en = 16'h0000; irq_clr = 16'h0000;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (c < 8) begin
        reset = 1'b0; pin_raw = 16'hFFFF;
      end else if (c < 30) begin
        reset = 1'b1; pin_raw = 16'hFFFF;
        irq_en = 16'hFFFF; edge_sel = 16'h0000;
      end else begin
        reset = ((c % 500) == 250 || (c % 500) == 251) ? 1'b0 : 1'b1;
        prob = ((c / 200) % 2 == 0) ? 16 : 3;
        tog = '0;
        for (int i = 0; i < W; i++) tog[i] = ($urandom_range(prob - 1, 0) == 0);
        pin_raw = pin_raw ^ tog;
        if ($urandom_range(31, 0) == 0) irq_en   = W'($urandom);
        if ($urandom_range(31, 0) == 0) edge_sel = W'($urandom);
        irq_clr = W'($urandom & $urandom & $urandom);
      end
      if (!reset) model_clear();
      push_expect();
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compare DUT outputs against the oldest expectation, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({pin_db, pin_rise, pin_fall, irq_pend, irq} !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got db=%h rise=%h fall=%h pend=%h irq=%b, want db=%h rise=%h fall=%h pend=%h irq=%b",
                 $time, pin_db, pin_rise, pin_fall, irq_pend, irq,
                 e.db, e.rise, e.fall, e.pend, e.irq);
      end
    end
  end

endmodule
